// File: rtl/fsm_level_run_logger.sv
// Measures high runs of an upstream FSM level, drops runs shorter than MIN_LEN,
// and queues {saturated, length} records in a first-word-fall-through FIFO.
module fsm_level_run_logger #(
  parameter int CNT_W   = 8,
  parameter int DEPTH   = 4,
  parameter int MIN_LEN = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_level,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [CNT_W-1:0]         rec_len,
  output logic                     rec_sat,
  output logic [$clog2(DEPTH):0]   rec_count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] MIN_LEN_C = CNT_W'(MIN_LEN);
  localparam logic [AW-1:0]    PTR_ONE   = AW'(1'b1);
  localparam logic [AW:0]      OCC_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0]      OCC_FULL  = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [CNT_W-1:0] run_cnt_r, cnt_nxt_s;
  logic             sat_r, sat_nxt_s;
  logic             push_s;

  logic [CNT_W:0]   mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [AW:0]      count_r, count_nxt_s;
  logic             overflow_r;
  logic             valid_s, full_s, pop_s, wr_s, drop_s;

  // Run-measurement FSM: next state, counter update and push request.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = run_cnt_r;
    sat_nxt_s   = sat_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_level) begin
          state_nxt_s = RUN;
          cnt_nxt_s   = CNT_ONE;
          sat_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (in_level) begin
          // Counter holds at its maximum; the overrun attempt marks the run saturated.
          if (run_cnt_r == CNT_MAX) begin
            sat_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = run_cnt_r + CNT_ONE;
          end
        end else begin
          state_nxt_s = IDLE;
          push_s      = (run_cnt_r >= MIN_LEN_C);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CNT_W{1'b0}};
        sat_nxt_s   = 1'b0;
      end
    endcase
  end

  // FSM state and run counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      run_cnt_r <= {CNT_W{1'b0}};
      sat_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      run_cnt_r <= cnt_nxt_s;
      sat_r     <= sat_nxt_s;
    end
  end

  // FIFO handshake decode; a push into a full FIFO survives only if the head leaves.
  always_comb begin
    valid_s = (count_r != {(AW+1){1'b0}});
    full_s  = (count_r == OCC_FULL);
    pop_s   = valid_s & rec_ready;
    wr_s    = push_s & (~full_s | pop_s);
    drop_s  = push_s & full_s & ~pop_s;
    case ({wr_s, pop_s})
      2'b10:   count_nxt_s = count_r + OCC_ONE;
      2'b01:   count_nxt_s = count_r - OCC_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(CNT_W+1){1'b0}};
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_r[wr_ptr_r] <= {sat_r, run_cnt_r};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign rec_valid = valid_s;
  assign rec_len   = valid_s ? mem_r[rd_ptr_r][CNT_W-1:0] : {CNT_W{1'b0}};
  assign rec_sat   = valid_s & mem_r[rd_ptr_r][CNT_W];
  assign rec_count = count_r;
  assign overflow  = overflow_r;

endmodule
